// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, HCU handshake
// constant and vector-table defaults.
package interrupt_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_SERVICE = 2'b10
  } irq_state_e;

  localparam logic [3:0]  HCU_ST_INT_DEF = 4'h2;
  localparam logic [13:0] VEC_BASE_DEF   = 14'h0040;
  localparam int unsigned VEC_STRIDE_DEF = 4;

  // Vector address arithmetic is done in 14 bits so it wraps modulo 2^14.
  function automatic logic [13:0] calc_vector(input logic [13:0] base,
                                              input logic [13:0] stride,
                                              input logic [3:0]  id);
    return base + stride * {10'd0, id};
  endfunction

endpackage

// File: rtl/interrupt_controller_prio.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_priority_encoder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] req_i,
  output logic         valid_o,
  output logic [3:0]   idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Scan downwards so the lowest set index is the last assignment.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 4'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Single-level interrupt controller: edge-latched pending bits, mask and global
// enable, fixed-priority arbitration and an HCU request/acknowledge/return FSM.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 8,
  parameter logic [13:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEF,
  parameter logic [3:0]  HCU_ST_INT = HCU_ST_INT_DEF
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               gie_wr,
  input  logic               gie_wdata,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic [3:0]         control_state,
  input  logic               ret,
  output logic               interrupt,
  output logic [13:0]        int_vector,
  output logic               in_service,
  output logic [3:0]         active_id,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask_q
);

  irq_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_d;
  logic               gie_q, gie_d;
  logic               interrupt_q, interrupt_d;
  logic               in_service_q, in_service_d;
  logic [3:0]         active_id_q, active_id_d;
  logic [13:0]        vector_q, vector_d;
  logic               ack;
  logic [NUM_IRQ-1:0] eligible;
  logic               win_valid;
  logic [3:0]         win_idx;

  assign eligible = pending_q & mask_q & {NUM_IRQ{gie_q}};
  assign gie_d    = gie_wr  ? gie_wdata  : gie_q;
  assign mask_d   = mask_wr ? mask_wdata : mask_q;

  irq_priority_encoder #(.N(NUM_IRQ)) u_prio (
    .req_i   (eligible),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  // A fresh edge on the bit being acknowledged keeps it pending (set wins).
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pend
    assign pending_d[gi] = (irq_in[gi] & ~irq_prev_q[gi])
                         | (pending_q[gi] & ~(ack && (active_id_q == 4'(gi))));
  end

  always_comb begin
    state_d      = state_q;
    interrupt_d  = interrupt_q;
    in_service_d = in_service_q;
    active_id_d  = active_id_q;
    vector_d     = vector_q;
    ack          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        interrupt_d  = 1'b0;
        in_service_d = 1'b0;
        if (win_valid) begin
          state_d     = ST_REQ;
          active_id_d = win_idx;
          vector_d    = calc_vector(VEC_BASE, 14'(VEC_STRIDE), win_idx);
        end
      end
      ST_REQ: begin
        // Winner is frozen here; only the HCU acknowledge moves us on.
        interrupt_d = 1'b1;
        if (control_state == HCU_ST_INT) begin
          ack          = 1'b1;
          interrupt_d  = 1'b0;
          in_service_d = 1'b1;
          state_d      = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        interrupt_d = 1'b0;
        if (ret) begin
          in_service_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        interrupt_d  = 1'b0;
        in_service_d = 1'b0;
        active_id_d  = '0;
        vector_d     = '0;
      end
    endcase
  end

  // Falling-edge registers to line up with the HCU.
  always_ff @(negedge clock) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      irq_prev_q   <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      gie_q        <= 1'b0;
      interrupt_q  <= 1'b0;
      in_service_q <= 1'b0;
      active_id_q  <= '0;
      vector_q     <= '0;
    end else begin
      state_q      <= state_d;
      irq_prev_q   <= irq_in;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      gie_q        <= gie_d;
      interrupt_q  <= interrupt_d;
      in_service_q <= in_service_d;
      active_id_q  <= active_id_d;
      vector_q     <= vector_d;
    end
  end

  assign interrupt  = interrupt_q;
  assign int_vector = vector_q;
  assign in_service = in_service_q;
  assign active_id  = active_id_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Table-driven and randomized checks of interrupt_controller against a
// behavioural model of the request/acknowledge/return protocol.
module tb_interrupt_controller;

  logic        clock;
  logic        nreset;
  logic [7:0]  irq_in;
  logic        gie_wr, gie_wdata, mask_wr;
  logic [7:0]  mask_wdata;
  logic [3:0]  control_state;
  logic        ret;
  logic        interrupt;
  logic [13:0] int_vector;
  logic        in_service;
  logic [3:0]  active_id;
  logic [7:0]  pending;
  logic [7:0]  mask_q;

  int total = 0;
  int bad   = 0;

  interrupt_controller #(
    .NUM_IRQ    (8),
    .VEC_BASE   (14'h0040),
    .VEC_STRIDE (4),
    .HCU_ST_INT (4'h2)
  ) dut (
    .clock         (clock),
    .nreset        (nreset),
    .irq_in        (irq_in),
    .gie_wr        (gie_wr),
    .gie_wdata     (gie_wdata),
    .mask_wr       (mask_wr),
    .mask_wdata    (mask_wdata),
    .control_state (control_state),
    .ret           (ret),
    .interrupt     (interrupt),
    .int_vector    (int_vector),
    .in_service    (in_service),
    .active_id     (active_id),
    .pending       (pending),
    .mask_q        (mask_q)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic       rst_n;
    logic [7:0] irq;
    logic       gw;
    logic       gd;
    logic       mw;
    logic [7:0] md;
    logic [3:0] cs;
    logic       rt;
  } in_t;

  typedef struct packed {
    in_t         x;
    logic        e_int;
    logic [13:0] e_vec;
    logic        e_svc;
    logic [3:0]  e_id;
    logic [7:0]  e_pend;
    logic [7:0]  e_mask;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: mode 0 = idle, 1 = requesting, 2 = handler running.
  logic [7:0]  m_pend, m_mask, m_prev;
  logic        m_gie, m_int, m_svc;
  logic [13:0] m_vec;
  int          m_mode, m_id;

  task automatic model_step(input in_t x);
    logic [7:0] elig;
    logic [7:0] nxt;
    if (!x.rst_n) begin
      m_pend = 0; m_mask = 0; m_prev = 0; m_gie = 0;
      m_int = 0; m_svc = 0; m_vec = 0; m_mode = 0; m_id = 0;
      return;
    end
    elig = m_gie ? (m_pend & m_mask) : 8'h00;
    nxt  = m_pend;
    if (m_mode == 0) begin
      m_int = 0; m_svc = 0;
      for (int i = 7; i >= 0; i--) begin
        if (elig[i]) begin
          m_mode = 1; m_id = i; m_vec = 14'(64 + 4 * i);
        end
      end
    end else if (m_mode == 1) begin
      if (x.cs == 4'h2) begin
        nxt[m_id] = 1'b0; m_int = 0; m_svc = 1; m_mode = 2;
      end else begin
        m_int = 1;
      end
    end else if (x.rt) begin
      m_svc = 0; m_mode = 0;
    end
    m_pend = nxt | (x.irq & ~m_prev);
    m_prev = x.irq;
    if (x.gw) m_gie = x.gd;
    if (x.mw) m_mask = x.md;
  endtask

  task automatic apply(input in_t x);
    nreset        = x.rst_n;
    irq_in        = x.irq;
    gie_wr        = x.gw;
    gie_wdata     = x.gd;
    mask_wr       = x.mw;
    mask_wdata    = x.md;
    control_state = x.cs;
    ret           = x.rt;
    model_step(x);
    @(negedge clock);
    @(posedge clock);
  endtask

  task automatic check(input string tag, input logic ei, input logic [13:0] ev,
                       input logic es, input logic [3:0] eid,
                       input logic [7:0] ep, input logic [7:0] em);
    total++;
    if ({interrupt, int_vector, in_service, active_id, pending, mask_q} !==
        {ei, ev, es, eid, ep, em}) begin
      bad++;
      $display("FAIL %s: got int=%b vec=%h svc=%b id=%0d pend=%h mask=%h, want int=%b vec=%h svc=%b id=%0d pend=%h mask=%h",
               tag, interrupt, int_vector, in_service, active_id, pending, mask_q,
               ei, ev, es, eid, ep, em);
    end else begin
      $display("txn %s: int=%b vec=%h svc=%b id=%0d pend=%h mask=%h",
               tag, interrupt, int_vector, in_service, active_id, pending, mask_q);
    end
  endtask

  task automatic add(input logic r, input logic [7:0] irq, input logic gw, input logic gd,
                     input logic mw, input logic [7:0] md, input logic [3:0] cs, input logic rt,
                     input logic ei, input logic [13:0] ev, input logic es,
                     input logic [3:0] eid, input logic [7:0] ep, input logic [7:0] em);
    vec_t v;
    v.x     = '{rst_n: r, irq: irq, gw: gw, gd: gd, mw: mw, md: md, cs: cs, rt: rt};
    v.e_int = ei; v.e_vec = ev; v.e_svc = es; v.e_id = eid; v.e_pend = ep; v.e_mask = em;
    tbl.push_back(v);
  endtask

  initial begin
    in_t r;
    nreset = 0; irq_in = 0; gie_wr = 0; gie_wdata = 0; mask_wr = 0;
    mask_wdata = 0; control_state = 0; ret = 0;

    //   rst irq  gw gd mw md    cs   rt   int vec       svc id pend   mask
    add(0, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 0, 14'h0000, 0, 0, 8'h00, 8'h00); // reset
    add(1, 8'h00, 1, 1, 1, 8'hFF, 4'h0, 0, 0, 14'h0000, 0, 0, 8'h00, 8'hFF);
    add(1, 8'h08, 0, 0, 0, 8'h00, 4'h0, 0, 0, 14'h0000, 0, 0, 8'h08, 8'hFF); // edge irq3
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 0, 14'h004C, 0, 3, 8'h08, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 1, 14'h004C, 0, 3, 8'h08, 8'hFF); // N+2
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h2, 0, 0, 14'h004C, 1, 3, 8'h00, 8'hFF); // ack
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 1, 0, 14'h004C, 0, 3, 8'h00, 8'hFF); // ret
    add(1, 8'h22, 0, 0, 0, 8'h00, 4'h0, 0, 0, 14'h004C, 0, 3, 8'h22, 8'hFF); // irq5+1
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 0, 14'h0044, 0, 1, 8'h22, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 1, 14'h0044, 0, 1, 8'h22, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h2, 0, 0, 14'h0044, 1, 1, 8'h20, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 1, 0, 14'h0044, 0, 1, 8'h20, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 0, 14'h0054, 0, 5, 8'h20, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 1, 14'h0054, 0, 5, 8'h20, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h2, 0, 0, 14'h0054, 1, 5, 8'h00, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 1, 0, 14'h0054, 0, 5, 8'h00, 8'hFF);
    add(1, 8'h00, 0, 0, 1, 8'hFE, 4'h0, 0, 0, 14'h0054, 0, 5, 8'h00, 8'hFE); // mask FE
    add(1, 8'h01, 0, 0, 0, 8'h00, 4'h0, 0, 0, 14'h0054, 0, 5, 8'h01, 8'hFE);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 0, 14'h0054, 0, 5, 8'h01, 8'hFE);
    add(1, 8'h00, 0, 0, 1, 8'hFF, 4'h0, 0, 0, 14'h0054, 0, 5, 8'h01, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 0, 14'h0040, 0, 0, 8'h01, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 1, 14'h0040, 0, 0, 8'h01, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h2, 0, 0, 14'h0040, 1, 0, 8'h00, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 1, 0, 14'h0040, 0, 0, 8'h00, 8'hFF);
    add(1, 8'h10, 0, 0, 0, 8'h00, 4'h0, 0, 0, 14'h0040, 0, 0, 8'h10, 8'hFF); // irq4
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 0, 14'h0050, 0, 4, 8'h10, 8'hFF);
    add(1, 8'h01, 0, 0, 0, 8'h00, 4'h0, 0, 1, 14'h0050, 0, 4, 8'h11, 8'hFF); // no re-arb
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 1, 14'h0050, 0, 4, 8'h11, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h2, 0, 0, 14'h0050, 1, 4, 8'h01, 8'hFF);
    add(0, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 0, 14'h0000, 0, 0, 8'h00, 8'h00); // reset in SERVICE
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 1, 0, 14'h0000, 0, 0, 8'h00, 8'h00); // stray ret
    add(1, 8'h00, 1, 1, 1, 8'hFF, 4'h0, 0, 0, 14'h0000, 0, 0, 8'h00, 8'hFF);
    add(1, 8'h04, 0, 0, 0, 8'h00, 4'h0, 0, 0, 14'h0000, 0, 0, 8'h04, 8'hFF);
    add(1, 8'h00, 1, 0, 0, 8'h00, 4'h0, 0, 0, 14'h0048, 0, 2, 8'h04, 8'hFF); // gie off
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 1, 14'h0048, 0, 2, 8'h04, 8'hFF); // not withdrawn
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h2, 0, 0, 14'h0048, 1, 2, 8'h00, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 1, 0, 14'h0048, 0, 2, 8'h00, 8'hFF);
    add(1, 8'h02, 0, 0, 0, 8'h00, 4'h0, 0, 0, 14'h0048, 0, 2, 8'h02, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 0, 14'h0048, 0, 2, 8'h02, 8'hFF); // gated
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 0, 14'h0048, 0, 2, 8'h02, 8'hFF);
    add(1, 8'h00, 1, 1, 0, 8'h00, 4'h0, 0, 0, 14'h0048, 0, 2, 8'h02, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 0, 14'h0044, 0, 1, 8'h02, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 1, 14'h0044, 0, 1, 8'h02, 8'hFF);
    add(1, 8'h02, 0, 0, 0, 8'h00, 4'h2, 0, 0, 14'h0044, 1, 1, 8'h02, 8'hFF); // set wins
    add(1, 8'h02, 0, 0, 0, 8'h00, 4'h0, 1, 0, 14'h0044, 0, 1, 8'h02, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 0, 14'h0044, 0, 1, 8'h02, 8'hFF);
    add(1, 8'h00, 0, 0, 0, 8'h00, 4'h0, 0, 1, 14'h0044, 0, 1, 8'h02, 8'hFF);

    foreach (tbl[k]) begin
      apply(tbl[k].x);
      check($sformatf("vec%0d", k), tbl[k].e_int, tbl[k].e_vec, tbl[k].e_svc,
            tbl[k].e_id, tbl[k].e_pend, tbl[k].e_mask);
    end

    r = '{rst_n: 1'b0, irq: 8'h00, gw: 1'b0, gd: 1'b0, mw: 1'b0, md: 8'h00, cs: 4'h0, rt: 1'b0};
    apply(r);
    r = '{rst_n: 1'b1, irq: 8'h00, gw: 1'b1, gd: 1'b1, mw: 1'b1, md: 8'hFF, cs: 4'h0, rt: 1'b0};
    apply(r);
    for (int n = 0; n < 400; n++) begin
      r.rst_n = ($urandom_range(0, 99) != 0);
      r.irq   = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      r.gw    = ($urandom_range(0, 15) == 0);
      r.gd    = ($urandom_range(0, 3) != 0);
      r.mw    = ($urandom_range(0, 15) == 0);
      r.md    = 8'($urandom_range(0, 255)) | 8'($urandom_range(0, 255));
      r.cs    = ($urandom_range(0, 2) == 0) ? 4'h2 : 4'($urandom_range(0, 15));
      r.rt    = ($urandom_range(0, 3) == 0);
      apply(r);
      check($sformatf("rnd%0d", n), m_int, m_vec, m_svc, 4'(m_id), m_pend, m_mask);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
